// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared widths and the write-back entry type for the register-file write arbiter
package reg_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: circular buffer of write-back entries; ports: clk/rst, push/din, pop/dout, full/empty/count
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end
  assign dout = mem[head];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges primary and buffered secondary write-backs onto one register-file write port
// Ports: p_* primary write-back (never stalled); s_* secondary ready/valid write-back; issue_* marks
// a long-latency destination pending in busy; stall_req asks the pipeline to hold primary write-backs;
// we/wa/wd drive the register-file write port.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  input  logic [REG_ADDR_W-1:0] p_rd,
  input  logic [XLEN-1:0]       p_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [REG_ADDR_W-1:0] s_rd,
  input  logic [XLEN-1:0]       s_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  stall_req,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wa,
  output logic [XLEN-1:0]       wd
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  wb_entry_t head;
  logic full, empty, push, pop, p_win;
  logic [CW-1:0] count, count_nxt;
  logic [3:0] starve;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din('{rd: s_rd, data: s_data}), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  assign s_ready = !full;
  // writes to x0 are accepted but dropped so they never reach the port
  assign push = s_valid && s_ready && s_rd != '0;
  assign p_win = p_valid && p_rd != '0;
  assign pop = !empty && !p_win;
  assign count_nxt = count + CW'(push) - CW'(pop);
  always_comb begin
    we = p_win || !empty;
    wa = p_win ? p_rd : (!empty ? head.rd : '0);
    wd = p_win ? p_data : (!empty ? head.data : '0);
    set_mask = (issue_valid && issue_rd != '0) ? (NUM_REGS'(1) << issue_rd) : '0;
    clr_mask = pop ? (NUM_REGS'(1) << head.rd) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      starve <= '0;
      stall_req <= 1'b0;
    end else begin
      // OR-ing the set after the clear lets a fresh issue win over a retiring write
      busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      if (pop) starve <= '0;
      else if (!empty && p_win && starve != LIM) starve <= starve + 1'b1;
      if (count_nxt == '0) stall_req <= 1'b0;
      else if (starve == LIM) stall_req <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
  logic clk = 0, rst = 1;
  logic p_valid = 0, s_valid = 0, issue_valid = 0;
  logic [4:0] p_rd = 0, s_rd = 0, issue_rd = 0;
  logic [31:0] p_data = 0, s_data = 0;
  logic s_ready, stall_req, we;
  logic [31:0] busy, wd;
  logic [4:0] wa;
  int checks = 0, errors = 0;

  reg_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy), .stall_req(stall_req),
    .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst = 0;
    tick();
    p_valid = 1; p_rd = 5; p_data = 32'hA5A5A5A5;
    #1;
    chk("p_we", 32'(we), 32'd1);
    chk("p_wa", 32'(wa), 32'd5);
    chk("p_wd", wd, 32'hA5A5A5A5);
    chk("p_busy", busy, 32'd0);
    chk("p_s_ready", 32'(s_ready), 32'd1);
    tick();
    p_valid = 0;
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    #1;
    chk("issue_busy7", busy, 32'h0000_0080);
    s_valid = 1; s_rd = 7; s_data = 32'h12345678;
    #1;
    chk("s_ready_idle", 32'(s_ready), 32'd1);
    chk("we_before_accept", 32'(we), 32'd0);
    tick();
    s_valid = 0;
    #1;
    chk("s_we", 32'(we), 32'd1);
    chk("s_wa", 32'(wa), 32'd7);
    chk("s_wd", wd, 32'h12345678);
    chk("busy7_held", busy, 32'h0000_0080);
    tick();
    chk("s_we_after_pop", 32'(we), 32'd0);
    chk("busy7_cleared", busy, 32'd0);
    p_valid = 1; p_rd = 3; p_data = 32'h33333333;
    s_valid = 1; s_rd = 9; s_data = 32'h99;
    tick();
    s_rd = 10; s_data = 32'hAA;
    #1;
    chk("starve_ready1", 32'(s_ready), 32'd1);
    chk("starve_primary_wa", 32'(wa), 32'd3);
    tick();
    s_valid = 0;
    #1;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("stall_early", 32'(stall_req), 32'd0);
    tick();
    tick();
    tick();
    chk("stall_edge4", 32'(stall_req), 32'd0);
    tick();
    chk("stall_edge5", 32'(stall_req), 32'd1);
    chk("stall_primary_wa", 32'(wa), 32'd3);
    chk("stall_primary_wd", wd, 32'h33333333);
    p_valid = 0;
    #1;
    chk("drain1_wa", 32'(wa), 32'd9);
    chk("drain1_wd", wd, 32'h99);
    tick();
    chk("drain2_wa", 32'(wa), 32'd10);
    chk("drain2_wd", wd, 32'hAA);
    chk("drain2_stall", 32'(stall_req), 32'd1);
    chk("drain2_ready", 32'(s_ready), 32'd1);
    tick();
    chk("drained_we", 32'(we), 32'd0);
    chk("drained_stall", 32'(stall_req), 32'd0);
    p_valid = 1; p_rd = 0; p_data = 32'hDEAD;
    s_valid = 1; s_rd = 4; s_data = 32'h44;
    tick();
    s_rd = 0; s_data = 32'hBAD;
    #1;
    chk("x0_ready", 32'(s_ready), 32'd1);
    chk("x0_we", 32'(we), 32'd1);
    chk("x0_wa", 32'(wa), 32'd4);
    chk("x0_wd", wd, 32'h44);
    tick();
    s_valid = 0;
    #1;
    chk("x0_drop_we", 32'(we), 32'd0);
    p_valid = 0;
    tick();
    chk("x0_never_we", 32'(we), 32'd0);
    s_valid = 1; s_rd = 8; s_data = 32'h88;
    tick();
    s_valid = 0;
    issue_valid = 1; issue_rd = 8;
    #1;
    chk("setwin_wa", 32'(wa), 32'd8);
    tick();
    issue_valid = 0;
    #1;
    chk("setwin_busy8", busy, 32'h0000_0100);
    chk("setwin_we", 32'(we), 32'd0);
    issue_valid = 1; issue_rd = 6;
    tick();
    issue_valid = 0;
    p_valid = 1; p_rd = 2; p_data = 32'h22;
    s_valid = 1; s_rd = 11; s_data = 32'hB;
    tick();
    s_rd = 12; s_data = 32'hC;
    tick();
    s_valid = 0;
    #1;
    chk("pre_rst_full", 32'(s_ready), 32'd0);
    chk("pre_rst_busy", busy, 32'h0000_0140);
    #1;
    rst = 1; p_valid = 0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 0;
    #1;
    chk("post_rst_we", 32'(we), 32'd0);
    tick();
    chk("post_rst_we2", 32'(we), 32'd0);
    chk("post_rst_wa", 32'(wa), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
